sap_alu_flag_unit: RTL and testbench

- Accumulator datapath stage for the 8-bit SAP computer, sitting directly upstream of the control unit FSM.
- Holds the A (accumulator), B (operand) and OUT registers, executes ADD/SUB/INCA/DECR, and maintains the 2-bit flag register {zero, carry}.
- The control unit samples this flag register to resolve JMPZ/JMPC.
- Driven by individual control-word bits; exchanges data with the shared 8-bit bus.

---
 rtl/sap_pkg.sv | 21 ++
 rtl/sap_alu_core.sv | 41 ++++
 rtl/sap_alu_flag_unit.sv | 79 +++++++
 tb/tb_sap_alu_flag_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP accumulator stage and the control unit.
// SAP_OVERFLOW_FLAG_EN widens the flag register with a signed-overflow bit.
package sap_pkg;

  localparam int DATA_W = 8;
`ifdef SAP_OVERFLOW_FLAG_EN
  localparam int FLAG_W = 3;
`else
  localparam int FLAG_W = 2;
`endif

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_DEC = 2'b11;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/sap_alu_core.sv
// Combinational SAP ALU: every op is a single 9-bit add of A, a selected operand and a carry-in.
// SAP_OVERFLOW_FLAG_EN adds the signed-overflow output v.
module sap_alu_core
  import sap_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y,
`ifdef SAP_OVERFLOW_FLAG_EN
  output logic              v,
`endif
  output logic              c
);

  logic [DATA_W-1:0] opnd;
  logic              cin;
  logic [DATA_W:0]   sum;

  // SUB is A + ~B + 1, so carry out means "no borrow".
  always_comb begin
    opnd = b;
    cin  = 1'b0;
    case (op)
      ALU_ADD: begin opnd = b;           cin = 1'b0; end
      ALU_SUB: begin opnd = ~b;          cin = 1'b1; end
      ALU_INC: begin opnd = '0;          cin = 1'b1; end
      ALU_DEC: begin opnd = {DATA_W{1'b1}}; cin = 1'b0; end
      default: begin opnd = b;           cin = 1'b0; end
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, opnd} + {{DATA_W{1'b0}}, cin};
  assign y   = sum[DATA_W-1:0];
  assign c   = sum[DATA_W];

`ifdef SAP_OVERFLOW_FLAG_EN
  assign v = (a[DATA_W-1] == opnd[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
`endif

endmodule

// File: rtl/sap_alu_flag_unit.sv
// SAP accumulator stage: A/B/OUT registers, registered {zero, carry} flags and bus drive.
// SAP_OVERFLOW_FLAG_EN adds flags[2] = signed overflow.
module sap_alu_flag_unit
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              a_load,
  input  logic              b_load,
  input  logic [1:0]        alu_op,
  input  logic              alu_exec,
  input  logic              a_out_en,
  input  logic              alu_out_en,
  input  logic              out_load,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              bus_conflict,
  output logic [FLAG_W-1:0] flags,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] out_q
);

  logic [DATA_W-1:0] b_q;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              conflict_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
`ifdef SAP_OVERFLOW_FLAG_EN
  logic              alu_v;
`endif

  sap_alu_core u_core (
    .a  (a_q),
    .b  (b_q),
    .op (alu_op),
    .y  (alu_y),
`ifdef SAP_OVERFLOW_FLAG_EN
    .v  (alu_v),
`endif
    .c  (alu_c)
  );

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = (alu_y == '0);
    flags_d[FLAG_C] = alu_c;
`ifdef SAP_OVERFLOW_FLAG_EN
    flags_d[FLAG_V] = alu_v;
`endif
  end

  // a_load beats alu_exec; flags only move on a completed exec.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
      flags_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (a_load) begin
        a_q <= bus_in;
      end else if (alu_exec) begin
        a_q     <= alu_y;
        flags_q <= flags_d;
      end
      if (b_load)   b_q   <= bus_in;
      if (out_load) out_q <= bus_in;
      conflict_q <= a_out_en & alu_out_en;
    end
  end

  assign bus_out      = a_out_en ? a_q : (alu_out_en ? alu_y : '0);
  assign bus_drive    = a_out_en | alu_out_en;
  assign bus_conflict = conflict_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_sap_alu_flag_unit.sv
// Directed bench for sap_alu_flag_unit with hand-computed expectations.
module tb_sap_alu_flag_unit;
  import sap_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] bus_in;
  logic              a_load, b_load, alu_exec, a_out_en, alu_out_en, out_load;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] bus_out, a_q, out_q;
  logic              bus_drive, bus_conflict;
  logic [FLAG_W-1:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  sap_alu_flag_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
    .a_load       (a_load),
    .b_load       (b_load),
    .alu_op       (alu_op),
    .alu_exec     (alu_exec),
    .a_out_en     (a_out_en),
    .alu_out_en   (alu_out_en),
    .out_load     (out_load),
    .bus_out      (bus_out),
    .bus_drive    (bus_drive),
    .bus_conflict (bus_conflict),
    .flags        (flags),
    .a_q          (a_q),
    .out_q        (out_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    bus_in = v; a_load = 1'b1; tick(); a_load = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v);
    bus_in = v; b_load = 1'b1; tick(); b_load = 1'b0;
  endtask

  task automatic exec(input logic [1:0] op);
    alu_op = op; alu_exec = 1'b1; tick(); alu_exec = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus_in = '0; a_load = 0; b_load = 0; alu_exec = 0;
    a_out_en = 0; alu_out_en = 0; out_load = 0; alu_op = ALU_ADD;
    tick();
    check("rst_a", a_q, 32'h00);
    check("rst_flags", flags, 32'h0);
    check("rst_out", out_q, 32'h00);
    check("rst_conflict", bus_conflict, 32'h0);
    check("rst_bus_out", bus_out, 32'h00);
    check("rst_bus_drive", bus_drive, 32'h0);
    rst = 1'b1;
    tick();

    // INCA wrap, then an asynchronous reset in the middle of a load.
    load_a(8'hFF);
    exec(ALU_INC);
    check("inc_ff_a", a_q, 32'h00);
    check("inc_ff_flags", flags, 32'h3);
    bus_in = 8'h5A; a_load = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_rst_a", a_q, 32'h00);
    check("async_rst_flags", flags, 32'h0);
    tick();
    check("rst_hold_no_load", a_q, 32'h00);
    rst = 1'b1;
    tick();
    check("load_after_rst", a_q, 32'h5A);
    a_load = 1'b0;

    // ADD wrap-around, then flags must hold across idle and non-exec loads.
    load_a(8'hF0);
    load_b(8'h20);
    exec(ALU_ADD);
    check("add_wrap_a", a_q, 32'h10);
    check("add_wrap_flags", flags, 32'h1);
    tick();
    check("hold_idle", flags, 32'h1);
    bus_in = 8'h00; out_load = 1'b1; tick(); out_load = 1'b0;
    check("hold_outload", flags, 32'h1);
    load_b(8'h33);
    check("hold_bload", flags, 32'h1);

    // SUB to zero, then borrow.
    load_a(8'h33);
    exec(ALU_SUB);
    check("sub_zero_a", a_q, 32'h00);
    check("sub_zero_flags", flags, 32'h3);
    load_b(8'h01);
    exec(ALU_SUB);
    check("sub_borrow_a", a_q, 32'hFF);
    check("sub_borrow_flags", flags, 32'h0);

    // INCA / DECR boundaries.
    exec(ALU_INC);
    check("inc_a", a_q, 32'h00);
    check("inc_flags", flags, 32'h3);
    exec(ALU_DEC);
    check("dec_00_a", a_q, 32'hFF);
    check("dec_00_flags", flags, 32'h0);
    load_a(8'h01);
    exec(ALU_DEC);
    check("dec_01_a", a_q, 32'h00);
    check("dec_01_flags", flags, 32'h3);

    // a_load beats alu_exec; flags untouched.
    bus_in = 8'h77; a_load = 1'b1; alu_exec = 1'b1; alu_op = ALU_DEC;
    tick();
    a_load = 1'b0; alu_exec = 1'b0;
    check("prio_a", a_q, 32'h77);
    check("prio_flags", flags, 32'h3);

    // b_load with alu_exec uses the old B (01); new B (05) applies next.
    load_a(8'h10);
    bus_in = 8'h05; b_load = 1'b1; alu_exec = 1'b1; alu_op = ALU_ADD;
    tick();
    b_load = 1'b0; alu_exec = 1'b0;
    check("old_b_a", a_q, 32'h11);
    check("old_b_flags", flags, 32'h0);
    exec(ALU_ADD);
    check("new_b_a", a_q, 32'h16);

    // Bus drive and conflict pulse.
    alu_op = ALU_ADD; alu_out_en = 1'b1;
    #1;
    check("alu_drive", bus_out, 32'h1B);
    check("alu_drive_en", bus_drive, 32'h1);
    a_out_en = 1'b1;
    #1;
    check("both_drive_a_wins", bus_out, 32'h16);
    check("conflict_before_edge", bus_conflict, 32'h0);
    tick();
    a_out_en = 1'b0; alu_out_en = 1'b0;
    check("conflict_pulse", bus_conflict, 32'h1);
    #1;
    check("idle_bus_out", bus_out, 32'h00);
    check("idle_bus_drive", bus_drive, 32'h0);
    tick();
    check("conflict_clear", bus_conflict, 32'h0);
    check("flags_after_bus", flags, 32'h0);

    // OUT register load and hold.
    bus_in = 8'h3C; out_load = 1'b1; tick(); out_load = 1'b0;
    check("out_load", out_q, 32'h3C);
    bus_in = 8'hC3; tick();
    check("out_hold", out_q, 32'h3C);

`ifdef SAP_OVERFLOW_FLAG_EN
    load_a(8'h7F);
    load_b(8'h01);
    exec(ALU_ADD);
    check("ovf_add_a", a_q, 32'h80);
    check("ovf_add_flags", flags, 32'h4);
    exec(ALU_DEC);
    check("ovf_dec_a", a_q, 32'h7F);
    check("ovf_dec_flags", flags, 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
